// File: rtl/csr_to_banked_ram_bridge.sv
`default_nettype none
// ============================================================================
// Module   : csr_to_banked_ram_bridge
// Summary  : CSR external-memory port to NUM_BANKS single-port RAM banks,
//            with bank decode, configurable read latency and bit-level RMW.
// Revision : 1.0
// ============================================================================
module csr_to_banked_ram_bridge #(
  parameter int WORD_BIT_WIDTH = 32,
  parameter int DEPTH          = 8,
  parameter int NUM_BANKS      = 4,
  parameter int RAM_RD_LATENCY = 2,
  localparam int BPW = WORD_BIT_WIDTH / 8,
  localparam int WA  = $clog2(DEPTH),
  localparam int BA  = $clog2(BPW * DEPTH * NUM_BANKS)
) (
  input  logic                                i_clk,
  input  logic                                i_async_rst_n,
  input  logic                                i_acc_req,
  input  logic                                i_acc_req_is_wr,
  input  logic [BA-1:0]                       i_byte_addr,
  input  logic [WORD_BIT_WIDTH-1:0]           i_wr_data,
  input  logic [WORD_BIT_WIDTH-1:0]           i_wr_bit_en,
  output logic                                o_rd_ack,
  output logic [WORD_BIT_WIDTH-1:0]           o_rd_data,
  output logic                                o_wr_ack,
  output logic                                o_busy,
  output logic                                o_req_drop,
  output logic [NUM_BANKS-1:0]                o_ram_we,
  output logic [WA-1:0]                       o_ram_word_addr,
  output logic [WORD_BIT_WIDTH-1:0]           o_ram_wr_data,
  output logic [BPW-1:0]                      o_ram_wr_byte_en,
  input  logic [NUM_BANKS*WORD_BIT_WIDTH-1:0] i_ram_rd_data
);

  localparam int OB  = $clog2(BPW);
  localparam int BKW = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;
  localparam logic [2:0] c_lat = 3'(RAM_RD_LATENCY);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_RD_WAIT  = 3'd1;
  localparam logic [2:0] S_RMW_WAIT = 3'd2;
  localparam logic [2:0] S_RMW_WR   = 3'd3;
  localparam logic [2:0] S_ACK      = 3'd4;

  generate
    if (WORD_BIT_WIDTH < 8 || (WORD_BIT_WIDTH & (WORD_BIT_WIDTH - 1)) != 0 ||
        DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 ||
        NUM_BANKS < 1 || (NUM_BANKS & (NUM_BANKS - 1)) != 0 ||
        RAM_RD_LATENCY < 1 || RAM_RD_LATENCY > 4) begin : g_param_check
      $error("csr_to_banked_ram_bridge: invalid parameter set");
    end
  endgenerate

  logic [2:0]                r_state;
  logic [2:0]                r_lat_cnt;
  logic [BKW-1:0]            r_bank;
  logic [WORD_BIT_WIDTH-1:0] r_bit_en;
  logic                      r_rd_ack;
  logic [WORD_BIT_WIDTH-1:0] r_rd_data;
  logic                      r_wr_ack;
  logic                      r_busy;
  logic                      r_req_drop;
  logic [NUM_BANKS-1:0]      r_ram_we;
  logic [WA-1:0]             r_ram_word_addr;
  logic [WORD_BIT_WIDTH-1:0] r_ram_wr_data;
  logic [BPW-1:0]            r_ram_wr_byte_en;

  logic [BKW-1:0]            w_bank;
  logic [BPW-1:0]            w_byte_any;
  logic                      w_any_full;
  logic                      w_any_partial;
  logic [WORD_BIT_WIDTH-1:0] w_rd_word;
  logic [WORD_BIT_WIDTH-1:0] w_merge;
  logic                      w_lat_done;

  generate
    if (NUM_BANKS > 1) begin : g_bank_multi
      assign w_bank = i_byte_addr[BA-1 -: BKW];
    end else begin : g_bank_single
      assign w_bank = '0;
    end
    if (OB > 0) begin : g_unused_ofs
      logic w_unused_ofs;
      assign w_unused_ofs = ^i_byte_addr[OB-1:0];
    end
  endgenerate

  // Per-byte enable class: a byte that is neither all-0 nor all-1 forces RMW.
  always_comb begin
    w_byte_any    = '0;
    w_any_full    = 1'b0;
    w_any_partial = 1'b0;
    for (int i = 0; i < BPW; i++) begin
      w_byte_any[i] = |i_wr_bit_en[i*8 +: 8];
      if (&i_wr_bit_en[i*8 +: 8]) w_any_full = 1'b1;
      else if (w_byte_any[i])     w_any_partial = 1'b1;
    end
  end

  always_comb begin
    w_rd_word = '0;
    for (int b = 0; b < NUM_BANKS; b++) begin
      if (BKW'(b) == r_bank) w_rd_word = i_ram_rd_data[b*WORD_BIT_WIDTH +: WORD_BIT_WIDTH];
    end
  end

  // r_ram_wr_data holds the caller's write data until the RMW merge replaces it.
  assign w_merge    = (w_rd_word & ~r_bit_en) | (r_ram_wr_data & r_bit_en);
  assign w_lat_done = (r_lat_cnt == c_lat);

  always_ff @(posedge i_clk or negedge i_async_rst_n) begin
    if (!i_async_rst_n) begin
      r_state          <= S_IDLE;
      r_lat_cnt        <= '0;
      r_bank           <= '0;
      r_bit_en         <= '0;
      r_rd_ack         <= 1'b0;
      r_rd_data        <= '0;
      r_wr_ack         <= 1'b0;
      r_busy           <= 1'b0;
      r_req_drop       <= 1'b0;
      r_ram_we         <= '0;
      r_ram_word_addr  <= '0;
      r_ram_wr_data    <= '0;
      r_ram_wr_byte_en <= '0;
    end else begin
      r_req_drop <= i_acc_req && (r_state != S_IDLE);
      case (r_state)
        S_IDLE: begin
          if (i_acc_req) begin
            r_busy          <= 1'b1;
            r_bank          <= w_bank;
            r_bit_en        <= i_wr_bit_en;
            r_ram_word_addr <= i_byte_addr[OB +: WA];
            r_ram_wr_data   <= i_wr_data;
            r_lat_cnt       <= '0;
            if (!i_acc_req_is_wr) begin
              r_state <= S_RD_WAIT;
            end else if (w_any_partial) begin
              r_state <= S_RMW_WAIT;
            end else begin
              r_state <= S_RMW_WR;
              if (w_any_full) begin
                r_ram_we         <= NUM_BANKS'(1) << w_bank;
                r_ram_wr_byte_en <= w_byte_any;
              end
            end
          end
        end
        S_RD_WAIT: begin
          if (w_lat_done) begin
            r_rd_data <= w_rd_word;
            r_rd_ack  <= 1'b1;
            r_state   <= S_ACK;
          end else begin
            r_lat_cnt <= r_lat_cnt + 3'd1;
          end
        end
        S_RMW_WAIT: begin
          if (w_lat_done) begin
            r_ram_we         <= NUM_BANKS'(1) << r_bank;
            r_ram_wr_data    <= w_merge;
            r_ram_wr_byte_en <= '1;
            r_state          <= S_RMW_WR;
          end else begin
            r_lat_cnt <= r_lat_cnt + 3'd1;
          end
        end
        S_RMW_WR: begin
          r_ram_we         <= '0;
          r_ram_wr_byte_en <= '0;
          r_wr_ack         <= 1'b1;
          r_state          <= S_ACK;
        end
        S_ACK: begin
          r_rd_ack <= 1'b0;
          r_wr_ack <= 1'b0;
          r_busy   <= 1'b0;
          r_state  <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_rd_ack         = r_rd_ack;
  assign o_rd_data        = r_rd_data;
  assign o_wr_ack         = r_wr_ack;
  assign o_busy           = r_busy;
  assign o_req_drop       = r_req_drop;
  assign o_ram_we         = r_ram_we;
  assign o_ram_word_addr  = r_ram_word_addr;
  assign o_ram_wr_data    = r_ram_wr_data;
  assign o_ram_wr_byte_en = r_ram_wr_byte_en;

endmodule
`default_nettype wire

// File: tb/tb_csr_to_banked_ram_bridge.sv
`default_nettype none
// ============================================================================
// Module   : tb_csr_to_banked_ram_bridge
// Summary  : Directed bench for csr_to_banked_ram_bridge with banked RAM model.
// Revision : 1.0
// ============================================================================
module tb_csr_to_banked_ram_bridge;
  localparam int W     = 32;
  localparam int DEPTH = 8;
  localparam int NB    = 4;
  localparam int LAT   = 2;
  localparam int BPW   = W / 8;
  localparam int WA    = 3;
  localparam int BA    = 7;

  logic              clk;
  logic              rst_n;
  logic              acc_req;
  logic              acc_is_wr;
  logic [BA-1:0]     byte_addr;
  logic [W-1:0]      wr_data;
  logic [W-1:0]      wr_bit_en;
  logic              rd_ack;
  logic [W-1:0]      rd_data;
  logic              wr_ack;
  logic              busy;
  logic              req_drop;
  logic [NB-1:0]     ram_we;
  logic [WA-1:0]     ram_word_addr;
  logic [W-1:0]      ram_wr_data;
  logic [BPW-1:0]    ram_wr_byte_en;
  logic [NB*W-1:0]   ram_rd_data;
  logic              ram_clr;

  int                n_checks = 0;
  int                n_fail   = 0;
  logic [W-1:0]      sb_q[$];

  csr_to_banked_ram_bridge #(
    .WORD_BIT_WIDTH(W), .DEPTH(DEPTH), .NUM_BANKS(NB), .RAM_RD_LATENCY(LAT)
  ) dut (
    .i_clk(clk), .i_async_rst_n(rst_n), .i_acc_req(acc_req), .i_acc_req_is_wr(acc_is_wr),
    .i_byte_addr(byte_addr), .i_wr_data(wr_data), .i_wr_bit_en(wr_bit_en),
    .o_rd_ack(rd_ack), .o_rd_data(rd_data), .o_wr_ack(wr_ack), .o_busy(busy),
    .o_req_drop(req_drop), .o_ram_we(ram_we), .o_ram_word_addr(ram_word_addr),
    .o_ram_wr_data(ram_wr_data), .o_ram_wr_byte_en(ram_wr_byte_en),
    .i_ram_rd_data(ram_rd_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Write-first single-port banks (ram_sp_wf behaviour) with a LAT-deep read pipe.
  logic [W-1:0] mem  [NB][DEPTH];
  logic [W-1:0] pipe [NB][LAT];
  logic [W-1:0] ram_nxt;
  always @(posedge clk) begin
    for (int b = 0; b < NB; b++) begin
      if (ram_clr) begin
        for (int d = 0; d < DEPTH; d++) mem[b][d] <= '0;
      end else begin
        ram_nxt = mem[b][ram_word_addr];
        if (ram_we[b]) begin
          for (int y = 0; y < BPW; y++)
            if (ram_wr_byte_en[y]) ram_nxt[y*8 +: 8] = ram_wr_data[y*8 +: 8];
          mem[b][ram_word_addr] <= ram_nxt;
        end
        pipe[b][0] <= ram_nxt;
        for (int s = 1; s < LAT; s++) pipe[b][s] <= pipe[b][s-1];
      end
    end
  end
  for (genvar gb = 0; gb < NB; gb++) begin : g_rd
    assign ram_rd_data[gb*W +: W] = pipe[gb][LAT-1];
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [14:0] ctrl_outs();
    return {rd_ack, wr_ack, busy, req_drop, ram_we, ram_word_addr, ram_wr_byte_en};
  endfunction

  // Read data scoreboard: expectations queued at issue, consumed on o_rd_ack.
  always @(negedge clk) begin
    if (rst_n && rd_ack) begin
      check("rd_sb_nonempty", 128'(sb_q.size() != 0), 128'(1));
      if (sb_q.size() != 0) check("rd_data", 128'(rd_data), 128'(sb_q.pop_front()));
    end
  end

  task automatic run_op(input string tag, input logic wr, input logic [BA-1:0] addr,
                        input logic [W-1:0] wd, input logic [W-1:0] be, input logic [W-1:0] exp_rd,
                        input int exp_ack, input int exp_we_cyc, input logic [NB-1:0] exp_we,
                        input logic [W-1:0] exp_wdata, input logic [BPW-1:0] exp_be, input int repulse);
    int ack_cyc, we_cyc, we_cnt, wr_cnt, rd_cnt, drop_cyc, drop_cnt;
    logic busy_ok;
    logic [NB-1:0] o_we;
    logic [W-1:0] o_wd;
    logic [BPW-1:0] o_be;
    logic [WA-1:0] o_wa;
    ack_cyc = -1; we_cyc = -1; we_cnt = 0; wr_cnt = 0; rd_cnt = 0;
    drop_cyc = -1; drop_cnt = 0; busy_ok = 1'b1;
    o_we = '0; o_wd = '0; o_be = '0; o_wa = '0;
    acc_req = 1'b1; acc_is_wr = wr; byte_addr = addr; wr_data = wd; wr_bit_en = be;
    if (!wr) sb_q.push_back(exp_rd);
    for (int k = 1; k <= exp_ack + 1; k++) begin
      @(negedge clk);
      if (ram_we != '0) begin
        we_cnt++;
        if (we_cyc < 0) begin
          we_cyc = k; o_we = ram_we; o_wd = ram_wr_data; o_be = ram_wr_byte_en; o_wa = ram_word_addr;
        end
      end
      if ((rd_ack || wr_ack) && ack_cyc < 0) ack_cyc = k;
      if (wr_ack) wr_cnt++;
      if (rd_ack) rd_cnt++;
      if (req_drop) begin
        drop_cnt++;
        if (drop_cyc < 0) drop_cyc = k;
      end
      if (busy !== (k <= exp_ack)) busy_ok = 1'b0;
      acc_req = (k == repulse);
    end
    acc_req = 1'b0;
    check({tag, "_ack_cycle"}, 128'(ack_cyc), 128'(exp_ack));
    check({tag, "_ack_counts"}, {64'(rd_cnt), 64'(wr_cnt)}, wr ? {64'd0, 64'd1} : {64'd1, 64'd0});
    check({tag, "_busy_window"}, 128'(busy_ok), 128'(1));
    check({tag, "_we_cycle"}, {64'(we_cyc), 64'(we_cnt)},
          {64'(exp_we_cyc), (exp_we_cyc > 0) ? 64'd1 : 64'd0});
    if (exp_we_cyc > 0)
      check({tag, "_we_beat"}, {o_we, o_wa, o_wd, o_be},
            {exp_we, addr[4:2], exp_wdata, exp_be});
    check({tag, "_drop"}, {64'(drop_cyc), 64'(drop_cnt)},
          (repulse > 0) ? {64'(repulse + 1), 64'd1} : {64'hFFFF_FFFF_FFFF_FFFF, 64'd0});
  endtask

  initial begin
    int stray;
    rst_n = 1'b0; acc_req = 1'b0; acc_is_wr = 1'b0; byte_addr = '0;
    wr_data = '0; wr_bit_en = '0; ram_clr = 1'b1;
    repeat (2) @(negedge clk);
    check("reset_ctrl", 128'(ctrl_outs()), 128'(0));
    check("reset_data", {rd_data, ram_wr_data}, 128'(0));
    ram_clr = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    check("post_reset_ctrl", 128'(ctrl_outs()), 128'(0));

    //      tag      wr    addr   wd            bit_en        exp_rd        ack we_c we       wdata         be     rep
    run_op("wr64",   1'b1, 7'h64, 32'hDEADBEEF, 32'hFFFFFFFF, 32'h0,        2,  1,   4'b1000, 32'hDEADBEEF, 4'hF,  0);
    run_op("rd64",   1'b0, 7'h64, 32'h0,        32'h0,        32'hDEADBEEF, 4, -1,   4'b0000, 32'h0,        4'h0,  0);
    run_op("rd04",   1'b0, 7'h04, 32'h0,        32'h0,        32'h00000000, 4, -1,   4'b0000, 32'h0,        4'h0,  0);
    run_op("wr20",   1'b1, 7'h20, 32'h12345678, 32'h0000FF00, 32'h0,        2,  1,   4'b0010, 32'h12345678, 4'h2,  0);
    run_op("rd20",   1'b0, 7'h20, 32'h0,        32'h0,        32'h00005600, 4, -1,   4'b0000, 32'h0,        4'h0,  0);
    run_op("pre4c",  1'b1, 7'h4C, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0,        2,  1,   4'b0100, 32'hFFFFFFFF, 4'hF,  0);
    run_op("rmw4c",  1'b1, 7'h4C, 32'h00000000, 32'h000000F0, 32'h0,        5,  4,   4'b0100, 32'hFFFFFF0F, 4'hF,  0);
    run_op("rd4c",   1'b0, 7'h4C, 32'h0,        32'h0,        32'hFFFFFF0F, 4, -1,   4'b0000, 32'h0,        4'h0,  0);
    run_op("rddrop", 1'b0, 7'h00, 32'h0,        32'h0,        32'h00000000, 4, -1,   4'b0000, 32'h0,        4'h0,  2);
    run_op("rdack",  1'b0, 7'h64, 32'h0,        32'h0,        32'hDEADBEEF, 4, -1,   4'b0000, 32'h0,        4'h0,  4);
    run_op("wrnone", 1'b1, 7'h38, 32'hA5A5A5A5, 32'h00000000, 32'h0,        2, -1,   4'b0000, 32'h0,        4'h0,  0);
    run_op("rd38",   1'b0, 7'h38, 32'h0,        32'h0,        32'h00000000, 4, -1,   4'b0000, 32'h0,        4'h0,  0);

    // Partial write to 0x4C interrupted by reset between clock edges.
    acc_req = 1'b1; acc_is_wr = 1'b1; byte_addr = 7'h4C; wr_data = 32'h0; wr_bit_en = 32'h0000000F;
    @(negedge clk);
    acc_req = 1'b0;
    @(negedge clk);
    check("rst_mid_busy", 128'(busy), 128'(1));
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid_ctrl", 128'(ctrl_outs()), 128'(0));
    check("rst_mid_data", {rd_data, ram_wr_data}, 128'(0));
    stray = 0;
    repeat (2) begin
      @(negedge clk);
      if (rd_ack || wr_ack || ram_we != '0) stray++;
    end
    #2 rst_n = 1'b1;
    repeat (6) begin
      @(negedge clk);
      if (rd_ack || wr_ack || ram_we != '0) stray++;
    end
    check("rst_no_ack", 128'(stray), 128'(0));
    run_op("rd4c_post", 1'b0, 7'h4C, 32'h0, 32'h0, 32'hFFFFFF0F, 4, -1, 4'b0000, 32'h0, 4'h0, 0);

    @(negedge clk);
    check("sb_drained", 128'(sb_q.size()), 128'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end
endmodule
`default_nettype wire

// File: doc/csr_to_banked_ram_bridge.md
Name: csr_to_banked_ram_bridge

Overview:
- Successor to the single-RAM CSR-to-RAM bridge: connects one CSR external-memory request port to NUM_BANKS identical single-port RAM banks.
- Adds address-based bank decoding, a parametrised RAM read latency, and read-modify-write (RMW) for bit-granular write enables.
- Sits between the generated CSR block's external memory port and the banked RAM instances.

Parameters:
- WORD_BIT_WIDTH, 32, data word width; power of 2, >= 8.
- DEPTH, 8, words per bank; power of 2, >= 2.
- NUM_BANKS, 4, number of RAM banks; power of 2, >= 1.
- RAM_RD_LATENCY, 2, cycles from RAM address to valid read data; range 1..4.
- Derived: BPW = WORD_BIT_WIDTH/8; WA = $clog2(DEPTH); BA = $clog2(BPW*DEPTH*NUM_BANKS).

Ports:
- i_clk  in  1  clock
- i_async_rst_n  in  1  reset; asynchronous assert, active-low
- i_acc_req  in  1  single-cycle access request strobe
- i_acc_req_is_wr  in  1  1 = write, 0 = read
- i_byte_addr  in  BA  byte address
- i_wr_data  in  WORD_BIT_WIDTH  write data
- i_wr_bit_en  in  WORD_BIT_WIDTH  per-bit write enable
- o_rd_ack  out  1  read-complete pulse
- o_rd_data  out  WORD_BIT_WIDTH  read data; valid while o_rd_ack is high
- o_wr_ack  out  1  write-complete pulse
- o_busy  out  1  high while a request is in flight
- o_req_drop  out  1  pulse: request arrived while busy and was ignored
- o_ram_we  out  NUM_BANKS  per-bank write enable
- o_ram_word_addr  out  WA  word address, shared by all banks
- o_ram_wr_data  out  WORD_BIT_WIDTH  write data, shared
- o_ram_wr_byte_en  out  BPW  byte enables, shared
- i_ram_rd_data  in  NUM_BANKS*WORD_BIT_WIDTH  bank b occupies bits [b*W +: W]

Behaviour:
- Reset:
  - Interface: one clock; reset is asynchronous and active-low. Port names are i_clk and i_async_rst_n.
  - Assertion immediately zeroes all outputs and returns the FSM to IDLE.
  - An operation interrupted by reset never acks.
- Address decode:
  - bank = i_byte_addr[BA-1 -: $clog2(NUM_BANKS)] (NUM_BANKS=1 → bank 0).
  - word = i_byte_addr[log2(BPW) +: WA].
  - Low byte-offset bits are ignored.
  - Address, bank, data and bit enables are latched at acceptance.
- Acceptance: i_acc_req is accepted only in IDLE (cycle 0); o_busy goes high from cycle 1 until the ack cycle inclusive.
- Dropped requests: i_acc_req while busy, including the ack cycle, is ignored and o_req_drop pulses in the next cycle.
- Write classification: each byte of i_wr_bit_en is classified as full (all 1), none (all 0) or partial.
- FSM states: IDLE, RD_WAIT, RMW_WAIT, RMW_WR, ACK.
- Read:
  - IDLE→RD_WAIT.
  - Cycle 1: o_ram_word_addr driven.
  - Data is sampled from the latched bank at cycle 1+RAM_RD_LATENCY.
  - Cycle 2+RAM_RD_LATENCY: o_rd_ack=1 with o_rd_data.
- Direct write (no partial byte, at least one full byte):
  - Cycle 1: o_ram_we[bank]=1; o_ram_wr_byte_en = per-byte OR of bit_en; o_ram_wr_data = i_wr_data.
  - Cycle 2: o_wr_ack.
- Empty write (bit_en all zero): no RAM access; o_wr_ack at cycle 2.
- RMW write (any partial byte):
  - Cycle 1: read issued (RMW_WAIT).
  - Cycle 1+RAM_RD_LATENCY: merge = (rd & ~bit_en) | (wr_data & bit_en).
  - Cycle 2+RAM_RD_LATENCY: RMW_WR; o_ram_we[bank]=1 with all byte enables.
  - Cycle 3+RAM_RD_LATENCY: o_wr_ack.
- Output timing:
  - o_ram_we is one-hot or zero and high for exactly one cycle per write.
  - o_rd_ack and o_wr_ack are single-cycle, mutually exclusive pulses.
  - All outputs are registered.
- ACK → IDLE on the next cycle: minimum spacing between accepted requests is ack cycle +1.
- Parameter check: invalid parameter values raise an elaboration error.

Test Plan:
(W=32, DEPTH=8, NUM_BANKS=4, RAM_RD_LATENCY=2; bank = addr[6:5], word = addr[4:2]; bench models RAMs as ram_sp_wf instances.)
- Write 0xDEADBEEF, bit_en 0xFFFFFFFF, to 0x64 → cycle 1: o_ram_we=4'b1000, word 1, byte_en 4'hF. Cycle 2: o_wr_ack. No other bank is written.
- Read 0x64 after that write → o_rd_ack at cycle 4 with o_rd_data=0xDEADBEEF. Read 0x04 → 0 (bank 0 untouched).
- Write 0x12345678, bit_en 0x0000FF00, to 0x20 → direct write with byte_en 4'b0010, ack at cycle 2. Read-back merges the new byte 0x56 into the old contents.
- Preload bank 2 word 3 (0x4C) with 0xFFFFFFFF, then write 0x00000000 with bit_en 0x000000F0 → RMW: read at cycle 1, o_ram_we=4'b0100 at cycle 4 with data 0xFFFFFF0F and byte_en 4'hF, o_wr_ack at cycle 5.
- Read in flight at 0x00 with i_acc_req re-pulsed at cycle 2 → o_req_drop at cycle 3; exactly one o_rd_ack. Empty-bit_en write → o_wr_ack at cycle 2 with o_ram_we never high.
- Assert i_async_rst_n low between clock edges mid-RMW → outputs go 0 immediately with no ack. After release, a new read completes normally.
